conv1_mac_accum: RTL and testbench
==================================

Name: conv1_mac_accum

Overview:
Upstream neighbour of the conv-layer-1 activation stage. Consumes a stream of (pixel, weight) tap pairs for one output pixel, computes a signed multiply-accumulate over KERNEL_TAPS taps plus a per-window bias, and applies ReLU plus saturation. Each result is presented as a 14-bit unsigned value on a valid/ready output that feeds the activation stage's 14-bit input directly.

Parameters:
KERNEL_TAPS, 9, taps per output window (3x3 kernel); legal range 1..64.
ACC_W, 24, signed accumulator width; must hold KERNEL_TAPS*255*128 + 2^15 without overflow.
OUT_W, 14, output width; saturation ceiling is 2^OUT_W-1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous abort of the current window; takes priority over all activity except rst
in_valid  in  1  tap pair valid
in_ready  out  1  block can accept a tap
in_pixel  in  8  unsigned pixel value
in_weight  in  8  signed two's-complement weight
in_bias  in  16  signed bias; sampled only with tap 0 of a window
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  ReLU-clamped, saturated sum (unsigned)
busy  out  1  high while a window is partially accumulated (tap_cnt != 0) or a result is held

Behaviour:
- Reset applies when rst=1 at a clk edge:
  - state=ACC, tap_cnt=0, acc=0
  - out_valid=0, out_data=0, busy=0
  - in_ready=1 in the first cycle after reset
- State ACC:
  - in_ready=1.
  - On a handshake (in_valid & in_ready), prod = $signed({1'b0,in_pixel}) * $signed(in_weight), a 17-bit signed value sign-extended to ACC_W.
  - tap_cnt==0: acc <= sext(in_bias) + prod.
  - Otherwise: acc <= acc + prod.
  - tap_cnt increments on each handshake.
  - On the handshake where tap_cnt==KERNEL_TAPS-1: compute final = acc + prod combinationally, register out_data = clamp(final), set out_valid=1, reset tap_cnt to 0, and go to HOLD.
  - Latency: out_valid rises in the cycle after the last tap's handshake edge.
- Clamp rule:
  - final < 0 -> 0.
  - final > 2^OUT_W-1 -> 2^OUT_W-1.
  - Otherwise final[OUT_W-1:0].
- State HOLD:
  - in_ready=0; out_valid=1.
  - out_data is stable until the output handshake.
  - On out_valid & out_ready: out_valid<=0 and go to ACC. in_ready is 1 in the next cycle; there is no same-cycle overlap.
  - Throughput is at best KERNEL_TAPS+1 cycles per result.
- No in_valid cycles: acc and tap_cnt hold. Gaps between taps are legal.
- clear=1 (synchronous, any state):
  - tap_cnt<=0, acc<=0, out_valid<=0, state<=ACC.
  - A held result that was not yet accepted is discarded.
  - A tap presented in the same cycle is dropped. in_ready is still driven per state, and the upstream producer must treat a clear cycle as a flush.
- rst mid-window or in HOLD: identical outcome to clear, plus out_data<=0.
- Input stability rules:
  - in_pixel, in_weight and in_bias need only be stable in the handshake cycle.
  - Changing in_bias on taps other than tap 0 has no effect.
- KERNEL_TAPS==1: every accepted tap produces a result (bias + prod) and the block goes directly to HOLD.
- Arithmetic widths:
  - Maximum magnitude = KERNEL_TAPS*255*128 + 32768.
  - For the defaults this is 326528, which fits in signed 24 bits with no internal wrap-around.
  - The implementation checks in an elaboration-time assertion that ACC_W is large enough.

Decomposition:
- Shared package conv1_pkg holds:
  - CONV1_PIX_W=8, CONV1_WGT_W=8, CONV1_BIAS_W=16, CONV1_OUT_W=14, CONV1_TAPS=9.
  - The state enum {ACC, HOLD}.
  - The activation stage's input width references CONV1_OUT_W from the same package.
- One natural sub-module: conv1_relu_sat. It is purely combinational, takes ACC_W signed in and produces OUT_W unsigned out, so it can be unit-tested alone.
- The multiplier is inferred inline.

Test Plan:
- 9 taps pixel=10, weight=2, bias=0, out_ready=1 -> one result, out_data=180; out_valid rises exactly 1 cycle after tap 9's handshake and is high for 1 cycle.
- 9 taps pixel=100, weight=-5, bias=100 -> sum -4400; out_data=0 (ReLU).
- 9 taps pixel=255, weight=127, bias=32767 -> sum 324232; out_data=16383 (saturate). Next window 9 taps pixel=1, weight=1, bias=-9 -> out_data=0 (zero boundary, accumulator fully reloaded).
- Backpressure: result 180 with out_ready=0 for 5 cycles -> out_valid stays 1 and out_data stays 180; in_ready=0 throughout; tap offers during the hold are not accepted. Raising out_ready -> one handshake, then in_ready=1 in the next cycle.
- Flush and reset mid-window:
  - Pulse clear after 4 taps, then send 9 taps pixel=1, weight=1, bias=3 -> out_data=12 (the first 4 taps are discarded).
  - Repeat with rst instead of clear -> same result; after rst, out_data=0 and out_valid=0.
- Random stream with random in_valid gaps and out_ready stalls over 1000 windows, pixels/weights/bias drawn from full ranges, compared against a reference model -> every out_data matches, and the result count equals the window count.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared types and widths for the conv-layer-1 datapath (MAC accumulator and activation stage).
package conv1_pkg;

  localparam int unsigned CONV1_PIX_W  = 8;
  localparam int unsigned CONV1_WGT_W  = 8;
  localparam int unsigned CONV1_BIAS_W = 16;
  localparam int unsigned CONV1_OUT_W  = 14;
  localparam int unsigned CONV1_TAPS   = 9;
  localparam int unsigned CONV1_ACC_W  = 24;
  // The unsigned pixel gains a zero sign bit, so the product is one bit wider than pixel + weight.
  localparam int unsigned CONV1_PROD_W = CONV1_PIX_W + CONV1_WGT_W + 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } conv1_state_e;

  typedef struct packed {
    logic        [CONV1_PIX_W-1:0]  pixel;
    logic signed [CONV1_WGT_W-1:0]  weight;
    logic signed [CONV1_BIAS_W-1:0] bias;
  } conv1_tap_t;

endpackage

// File: rtl/conv1_relu_sat.sv
// ReLU plus saturation: maps a signed accumulator sum onto an unsigned OUT_W range.
module conv1_relu_sat
  import conv1_pkg::*;
#(
  parameter int unsigned ACC_W = CONV1_ACC_W,
  parameter int unsigned OUT_W = CONV1_OUT_W
) (
  input  logic signed [ACC_W-1:0] din,
  output logic        [OUT_W-1:0] dout_c
);

  // Any set bit between the sign bit and OUT_W means the value exceeds the ceiling.
  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (din[ACC_W-1]) begin
      dout_c = '0;
    end else if (din[ACC_W-2:OUT_W] != '0) begin
      dout_c = '1;
    end
  end

endmodule

// File: rtl/conv1_mac_accum.sv
// Signed multiply-accumulate over one kernel window plus bias, with ReLU/saturation on a
// valid/ready result port that feeds the conv-layer-1 activation stage.
module conv1_mac_accum
  import conv1_pkg::*;
#(
  parameter int unsigned KERNEL_TAPS = CONV1_TAPS,
  parameter int unsigned ACC_W       = CONV1_ACC_W,
  parameter int unsigned OUT_W       = CONV1_OUT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic        [CONV1_PIX_W-1:0]  in_pixel,
  input  logic signed [CONV1_WGT_W-1:0]  in_weight,
  input  logic signed [CONV1_BIAS_W-1:0] in_bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic        [OUT_W-1:0]        out_data,
  output logic                           busy
);

  localparam int unsigned CNT_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
  localparam longint unsigned MAX_MAG = 64'(KERNEL_TAPS) * 64'd32640 + 64'd32768;

  // Reject parameter sets that would let the accumulator wrap or break the clamp slicing.
  if ((KERNEL_TAPS < 1) || (KERNEL_TAPS > 64)) begin : g_bad_taps
    $error("conv1_mac_accum: KERNEL_TAPS must be in 1..64");
  end
  if ((ACC_W > 63) || (ACC_W < OUT_W + 2) ||
      (MAX_MAG >= (64'd1 << (ACC_W - 1)))) begin : g_bad_acc_w
    $error("conv1_mac_accum: ACC_W too small for KERNEL_TAPS*255*128 + 2^15");
  end

  conv1_state_e                state_q, state_d;
  logic        [CNT_W-1:0]     tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [ACC_W-1:0]     base_c, sum_c;
  logic signed [CONV1_PROD_W-1:0] prod_c;
  logic        [OUT_W-1:0]     sat_c, out_data_d;
  logic                        out_valid_d, in_ready_d, busy_d;
  logic                        hs_c, last_c;
  conv1_tap_t                  tap_c;

  assign tap_c = '{pixel: in_pixel, weight: in_weight, bias: in_bias};

  // A tap offered during a clear cycle is flushed, never accumulated.
  assign hs_c   = in_valid & in_ready & ~clear;
  assign last_c = (tap_cnt_q == CNT_W'(KERNEL_TAPS - 1));

  assign prod_c = CONV1_PROD_W'($signed({1'b0, tap_c.pixel}) * $signed(tap_c.weight));
  assign base_c = (tap_cnt_q == '0) ? ACC_W'($signed(tap_c.bias)) : acc_q;
  assign sum_c  = base_c + ACC_W'(prod_c);

  conv1_relu_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_relu_sat (
    .din    (sum_c),
    .dout_c (sat_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    if (clear) begin
      state_d     = ACC;
      tap_cnt_d   = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (hs_c) begin
            acc_d = sum_c;
            if (last_c) begin
              tap_cnt_d   = '0;
              out_data_d  = sat_c;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              tap_cnt_d = tap_cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
    in_ready_d = (state_d == ACC);
    busy_d     = (tap_cnt_d != '0) | out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_conv1_mac_accum.sv
// Directed and randomised stimulus for conv1_mac_accum with hand-computed expected results.
module tb_conv1_mac_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic        [7:0]  in_pixel;
  logic signed [7:0]  in_weight;
  logic signed [15:0] in_bias;
  logic               out_valid;
  logic               out_ready;
  logic        [13:0] out_data;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int results = 0;

  conv1_mac_accum dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_weight (in_weight),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one tap and return once it has been accepted.
  task automatic send_tap(input logic [7:0] p, input logic [7:0] w, input logic [15:0] b);
    int n;
    n = 0;
    in_pixel  = p;
    in_weight = w;
    in_bias   = b;
    in_valid  = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("tap_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic window(input logic [7:0] p, input logic [7:0] w, input logic [15:0] b,
                        input int n);
    for (int i = 0; i < n; i++) send_tap(p, w, b);
  endtask

  // Accept one result and compare it.
  task automatic take(input string tag, input int exp);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk(tag, int'(out_data), exp);
      tick();
      results++;
    end
    out_ready = 1'b0;
  endtask

  function automatic int clamp(input int s);
    if (s < 0) return 0;
    if (s > 16383) return 16383;
    return s;
  endfunction

  initial begin
    logic        [7:0]  rp;
    logic signed [7:0]  rw;
    logic signed [15:0] rb;
    logic        [15:0] tb_bias;
    int                 sum;
    int                 got_results;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pixel = '0; in_weight = '0; in_bias = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic window with one-cycle result pulse
    out_ready = 1'b1;
    window(8'd10, 8'd2, 16'd0, 8);
    chk("t1_no_early_valid", int'(out_valid), 0);
    chk("t1_busy_mid", int'(busy), 1);
    send_tap(8'd10, 8'd2, 16'd0);
    chk("t1_latency", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 180);
    chk("t1_in_ready_hold", int'(in_ready), 0);
    tick();
    chk("t1_pulse", int'(out_valid), 0);
    chk("t1_in_ready_back", int'(in_ready), 1);
    chk("t1_busy_idle", int'(busy), 0);
    out_ready = 1'b0;

    // ReLU, saturation, zero boundary
    window(8'd100, 8'hFB, 16'd100, 9);
    take("t2_relu", 0);
    window(8'd255, 8'd127, 16'h7FFF, 9);
    take("t3_sat", 16383);
    window(8'd1, 8'd1, 16'hFFF7, 9);
    take("t3_zero", 0);

    // Backpressure with taps offered during hold
    window(8'd10, 8'd2, 16'd0, 9);
    in_pixel = 8'd200; in_weight = 8'd50; in_bias = 16'd999; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_data", int'(out_data), 180);
      chk("t4_hold_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_released", int'(out_valid), 0);
    chk("t4_in_ready", int'(in_ready), 1);
    chk("t4_no_tap_taken", int'(busy), 0);

    // Clear mid-window drops partial sum and the same-cycle tap
    window(8'd50, 8'd3, 16'd7, 4);
    clear = 1'b1;
    in_pixel = 8'd9; in_weight = 8'd9; in_bias = 16'd0; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_in_ready", int'(in_ready), 1);
    window(8'd1, 8'd1, 16'd3, 9);
    take("t5_clear", 12);

    // Reset mid-window
    window(8'd50, 8'd3, 16'd7, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_out_data", int'(out_data), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_busy", int'(busy), 0);
    window(8'd1, 8'd1, 16'd3, 9);
    take("t6_rst", 12);

    // Clear and reset while a result is held
    window(8'd10, 8'd2, 16'd0, 9);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t7_clear_hold_valid", int'(out_valid), 0);
    chk("t7_clear_hold_ready", int'(in_ready), 1);
    window(8'd1, 8'd1, 16'd3, 9);
    take("t7_after_clear", 12);
    window(8'd10, 8'd2, 16'd0, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_hold_valid", int'(out_valid), 0);
    chk("t7_rst_hold_data", int'(out_data), 0);

    // Random windows with gaps, stalls and bias noise on non-zero taps
    got_results = results;
    for (int wnd = 0; wnd < 1000; wnd++) begin
      rb = 16'($urandom);
      sum = int'(rb);
      for (int t = 0; t < 9; t++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        rp = 8'($urandom_range(0, 255));
        rw = 8'($urandom_range(0, 255));
        tb_bias = (t == 0) ? rb : 16'($urandom);
        sum += int'(rp) * int'(rw);
        send_tap(rp, rw, tb_bias);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      take("rand_data", clamp(sum));
    end
    chk("rand_result_count", results - got_results, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
